// File: rtl/framed_seq_tx.sv
// Serial frame transmitter: 11011 sync marker, MSB-first payload, optional even
// parity and a zero gap, feeding the 11011 sequence detector and an observe pin.
//
// state    | meaning
// S_IDLE   | line low, waiting for start
// S_SYNC   | emitting 1,1,0,1,1
// S_DATA   | emitting latched payload MSB first
// S_PARITY | emitting XOR of payload bits
// S_GAP    | emitting GAP_BITS zero bits, then done
module framed_seq_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       ser_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
  localparam logic [4:0] SYNC_PAT = 5'b11011;

  state_t     state_q;
  logic [7:0] pre_q, pre_d;
  logic [3:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic       ser_q, valid_q, busy_q, done_q;
  logic [7:0] cnt_q;
  logic       bit_end;
  logic [2:0] sync_sel;

  always_comb begin
    bit_end  = (pre_q == PRE_LAST);
    pre_d    = bit_end ? 8'd0 : pre_q + 8'd1;
    // SYNC_PAT is sent from bit 4 down; this picks the bit that follows bit_idx_q
    sync_sel = 3'd3 - bit_idx_q[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= 8'd0;
      bit_idx_q <= 4'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      ser_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        pre_q   <= 8'd0;
        valid_q <= 1'b0;
        ser_q   <= 1'b0;
        if (start) begin
          state_q   <= S_SYNC;
          bit_idx_q <= 4'd0;
          shift_q   <= data_in;
          parity_q  <= ^data_in;
          ser_q     <= SYNC_PAT[4];
          valid_q   <= 1'b1;
          busy_q    <= 1'b1;
        end
      end else if (!bit_end) begin
        pre_q   <= pre_d;
        valid_q <= 1'b0;
      end else begin
        pre_q <= pre_d;
        case (state_q)
          S_SYNC: begin
            valid_q <= 1'b1;
            if (bit_idx_q == 4'd4) begin
              state_q   <= S_DATA;
              bit_idx_q <= 4'd0;
              ser_q     <= shift_q[7];
              shift_q   <= {shift_q[6:0], 1'b0};
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              ser_q     <= SYNC_PAT[sync_sel];
            end
          end
          S_DATA: begin
            if (bit_idx_q == 4'd7) begin
              bit_idx_q <= 4'd0;
              if (PARITY_EN) begin
                state_q <= S_PARITY;
                ser_q   <= parity_q;
                valid_q <= 1'b1;
              end else begin
                state_q <= S_GAP;
                ser_q   <= 1'b0;
                valid_q <= 1'b0;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              ser_q     <= shift_q[7];
              shift_q   <= {shift_q[6:0], 1'b0};
              valid_q   <= 1'b1;
            end
          end
          S_PARITY: begin
            state_q   <= S_GAP;
            bit_idx_q <= 4'd0;
            ser_q     <= 1'b0;
            valid_q   <= 1'b0;
          end
          S_GAP: begin
            valid_q <= 1'b0;
            ser_q   <= 1'b0;
            if (bit_idx_q == GAP_LAST) begin
              state_q   <= S_IDLE;
              bit_idx_q <= 4'd0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              cnt_q     <= cnt_q + 8'd1;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ser_out   = ser_q;
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_framed_seq_tx.sv
// Directed bench for framed_seq_tx: defaults, prescaled parity, and no-parity
// wrap configurations, each on its own instance with its own reset.
module tb_framed_seq_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance a: defaults (CLKS_PER_BIT=1, GAP_BITS=2, PARITY_EN=1)
  logic rst_a, start_a, ser_a, valid_a, busy_a, done_a;
  logic [7:0] data_a, cnt_a;
  // instance p: CLKS_PER_BIT=3, parity on
  logic rst_p, start_p, ser_p, valid_p, busy_p, done_p;
  logic [7:0] data_p, cnt_p;
  // instance c: parity off
  logic rst_c, start_c, ser_c, valid_c, busy_c, done_c;
  logic [7:0] data_c, cnt_c;

  framed_seq_tx u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .data_in(data_a),
    .ser_out(ser_a), .bit_valid(valid_a), .busy(busy_a), .done(done_a), .frame_cnt(cnt_a)
  );

  framed_seq_tx #(.CLKS_PER_BIT(3), .GAP_BITS(2), .PARITY_EN(1'b1)) u_p (
    .clk(clk), .rst(rst_p), .start(start_p), .data_in(data_p),
    .ser_out(ser_p), .bit_valid(valid_p), .busy(busy_p), .done(done_p), .frame_cnt(cnt_p)
  );

  framed_seq_tx #(.CLKS_PER_BIT(1), .GAP_BITS(2), .PARITY_EN(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .data_in(data_c),
    .ser_out(ser_c), .bit_valid(valid_c), .busy(busy_c), .done(done_c), .frame_cnt(cnt_c)
  );

  // bit i of the result is the i-th serial bit of a frame (gap bits are 0)
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit par);
    logic [15:0] f;
    f = 16'd0;
    f[0] = 1'b1; f[1] = 1'b1; f[2] = 1'b0; f[3] = 1'b1; f[4] = 1'b1;
    for (int j = 0; j < 8; j++) f[5 + j] = d[7 - j];
    if (par) f[13] = ^d;
    return f;
  endfunction

  task automatic test_reset();
    rst_a = 1'b1; rst_p = 1'b1; rst_c = 1'b1;
    start_a = 1'b1; start_p = 1'b1; start_c = 1'b1;
    data_a = 8'hFF; data_p = 8'hFF; data_c = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ser_a, valid_a, busy_a, done_a, cnt_a} !== 12'd0) begin
        n_err++;
        $display("FAIL reset_a cyc %0d: got %b expected all zero", i, {ser_a, valid_a, busy_a, done_a, cnt_a});
      end
      n_cmp++;
      if ({ser_p, valid_p, busy_p, done_p, cnt_p, ser_c, valid_c, busy_c, done_c, cnt_c} !== 24'd0) begin
        n_err++;
        $display("FAIL reset_pc cyc %0d: got %b expected all zero", i,
                 {ser_p, valid_p, busy_p, done_p, cnt_p, ser_c, valid_c, busy_c, done_c, cnt_c});
      end
    end
    start_a = 1'b0; start_p = 1'b0; start_c = 1'b0;
    rst_a = 1'b0; rst_p = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || ser_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_nostart: busy=%b ser=%b expected 0 0", busy_a, ser_a);
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp;
    exp = frame_bits(8'hA5, 1'b1);
    data_a = 8'hA5; start_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_cmp++;
      if (ser_a !== exp[i] || busy_a !== 1'b1 || valid_a !== (i < 14) || done_a !== 1'b0) begin
        n_err++;
        $display("FAIL basic bit %0d: ser=%b busy=%b valid=%b done=%b expected ser=%b busy=1 valid=%b done=0",
                 i, ser_a, busy_a, valid_a, done_a, exp[i], (i < 14));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 8'd1 || ser_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b cnt=%0d ser=%b expected 1 0 1 0", done_a, busy_a, cnt_a, ser_a);
    end
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_after: done=%b busy=%b expected 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_parity_prescale();
    logic [15:0] exp;
    int pulses;
    exp = frame_bits(8'h01, 1'b1);
    pulses = 0;
    data_p = 8'h01; start_p = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      start_p = 1'b0;
      if (valid_p === 1'b1) pulses++;
      n_cmp++;
      if (ser_p !== exp[i / 3] || busy_p !== 1'b1 || valid_p !== ((i % 3 == 0) && (i / 3 < 14))) begin
        n_err++;
        $display("FAIL prescale cyc %0d: ser=%b busy=%b valid=%b expected ser=%b busy=1 valid=%b",
                 i, ser_p, busy_p, valid_p, exp[i / 3], ((i % 3 == 0) && (i / 3 < 14)));
      end
    end
    n_cmp++;
    if (pulses != 14) begin
      n_err++;
      $display("FAIL prescale_pulses: got %0d expected 14", pulses);
    end
    n_cmp++;
    if (exp[13] !== 1'b1) begin
      n_err++;
      $display("FAIL prescale_parity_model: got %b expected 1", exp[13]);
    end
    @(negedge clk);
    n_cmp++;
    if (done_p !== 1'b1 || busy_p !== 1'b0 || cnt_p !== 8'd1) begin
      n_err++;
      $display("FAIL prescale_done: done=%b busy=%b cnt=%0d expected 1 0 1", done_p, busy_p, cnt_p);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    exp1 = frame_bits(8'h81, 1'b1);
    exp2 = frame_bits(8'h3C, 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    data_a = 8'h81; start_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) start_a = 1'b0;
      if (i == 2) begin start_a = 1'b1; data_a = 8'hFF; end
      if (i == 3) begin start_a = 1'b0; data_a = 8'h00; end
      if (i == 13) begin start_a = 1'b1; data_a = 8'h3C; end
      n_cmp++;
      if (ser_a !== exp1[i] || busy_a !== 1'b1) begin
        n_err++;
        $display("FAIL ignored bit %0d: ser=%b busy=%b expected ser=%b busy=1", i, ser_a, busy_a, exp1[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 8'd1) begin
      n_err++;
      $display("FAIL b2b_done1: done=%b busy=%b cnt=%0d expected 1 0 1", done_a, busy_a, cnt_a);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_cmp++;
      if (ser_a !== exp2[i] || busy_a !== 1'b1 || valid_a !== (i < 14) || done_a !== 1'b0) begin
        n_err++;
        $display("FAIL b2b bit %0d: ser=%b busy=%b valid=%b done=%b expected ser=%b busy=1 valid=%b done=0",
                 i, ser_a, busy_a, valid_a, done_a, exp2[i], (i < 14));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b1 || cnt_a !== 8'd2) begin
      n_err++;
      $display("FAIL b2b_done2: done=%b cnt=%0d expected 1 2", done_a, cnt_a);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp;
    exp = frame_bits(8'h5A, 1'b1);
    data_a = 8'hFF; start_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    n_cmp++;
    if (ser_a !== 1'b1 || busy_a !== 1'b1 || cnt_a !== 8'd2) begin
      n_err++;
      $display("FAIL midrst_pre: ser=%b busy=%b cnt=%0d expected 1 1 2", ser_a, busy_a, cnt_a);
    end
    rst_a = 1'b1;
    #1;
    n_cmp++;
    if (ser_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 8'd0 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: ser=%b busy=%b cnt=%0d valid=%b expected 0 0 0 0", ser_a, busy_a, cnt_a, valid_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || ser_a !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_idle: busy=%b ser=%b expected 0 0", busy_a, ser_a);
    end
    data_a = 8'h5A; start_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_cmp++;
      if (ser_a !== exp[i] || busy_a !== 1'b1 || valid_a !== (i < 14)) begin
        n_err++;
        $display("FAIL midrst_frame bit %0d: ser=%b busy=%b valid=%b expected ser=%b busy=1 valid=%b",
                 i, ser_a, busy_a, valid_a, exp[i], (i < 14));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_a !== 1'b1 || cnt_a !== 8'd1) begin
      n_err++;
      $display("FAIL midrst_done: done=%b cnt=%0d expected 1 1", done_a, cnt_a);
    end
  endtask

  task automatic test_wrap_no_parity();
    logic [15:0] exp;
    logic [7:0]  d;
    int pulses;
    logic [7:0] exp_cnt;
    d = 8'd0;
    data_c = d; start_c = 1'b1;
    for (int k = 0; k < 256; k++) begin
      exp = frame_bits(d, 1'b0);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (valid_c === 1'b1) pulses++;
        n_cmp++;
        if (ser_c !== exp[i] || busy_c !== 1'b1 || valid_c !== (i < 13)) begin
          n_err++;
          $display("FAIL wrap frame %0d bit %0d: ser=%b busy=%b valid=%b expected ser=%b busy=1 valid=%b",
                   k, i, ser_c, busy_c, valid_c, exp[i], (i < 13));
        end
      end
      n_cmp++;
      if (pulses != 13) begin
        n_err++;
        $display("FAIL wrap_pulses frame %0d: got %0d expected 13", k, pulses);
      end
      @(negedge clk);
      exp_cnt = 8'(k + 1);
      n_cmp++;
      if (done_c !== 1'b1 || busy_c !== 1'b0 || cnt_c !== exp_cnt) begin
        n_err++;
        $display("FAIL wrap_done frame %0d: done=%b busy=%b cnt=%0d expected 1 0 %0d", k, done_c, busy_c, cnt_c, exp_cnt);
      end
      d = d + 8'h37;
      data_c = d;
      if (k == 255) start_c = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (cnt_c !== 8'd0 || busy_c !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_final: cnt=%0d busy=%b expected 0 0", cnt_c, busy_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_prescale();
    test_back_to_back();
    test_mid_reset();
    test_wrap_no_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/framed_seq_tx.md
# framed_seq_tx

Serial frame transmitter that produces the bit stream consumed by the team's Mealy "11011" non-overlapping sequence detector. On a start request it latches an 8-bit payload and emits one frame on a single serial line:
- the 5-bit sync marker 11011;
- the payload, MSB first;
- an optional even-parity bit;
- a run of zero gap bits, which keeps consecutive markers non-overlapping.

It sits between the `ui_in` control/data pins and the detector input, and also drives a pin so frames can be observed on silicon.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held; legal range 1..255.
- `GAP_BITS`, default 2: zero bits appended after each frame; legal range 1..15.
- `PARITY_EN`, default 1: 1 appends an even-parity bit after the payload, 0 omits it.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: frame request; sampled only while `busy`=0.
- `data_in`  in  8: payload, latched on the accepted `start` edge.
- `ser_out`  out  1: serial line; 0 when idle and during gap bits.
- `bit_valid`  out  1: high on the first clock of each sync, payload and parity bit; low for gap bits and idle.
- `busy`  out  1: high from the cycle after `start` is accepted until the frame (including gap) completes.
- `done`  out  1: one-cycle pulse when the frame completes.
- `frame_cnt`  out  8: count of completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, SYNC (5 bits), DATA (8 bits), PARITY (1 bit, skipped if `PARITY_EN`=0), GAP (`GAP_BITS` bits).
- Internal counters:
  - prescaler counts 0..`CLKS_PER_BIT`-1;
  - bit index counts 0..7;
  - shift register holds the latched payload.
- IDLE -> SYNC on a rising edge with `start`=1 and `busy`=0:
  - latch `data_in`;
  - compute parity = XOR of the payload bits.
- SYNC emits 1,1,0,1,1 in that order, then -> DATA.
- DATA emits `data_in[7]` down to `data_in[0]`, then:
  - -> PARITY if `PARITY_EN`=1;
  - -> GAP otherwise.
- PARITY emits the XOR of the 8 payload bits (even parity), then -> GAP.
- GAP emits 0 for `GAP_BITS` bit periods, then -> IDLE with these effects on that same edge:
  - `done` pulses for one cycle;
  - `busy` drops;
  - `frame_cnt` increments.
- `start` while `busy`=1 is ignored; it is not queued.
- Changes to `data_in` after acceptance have no effect on the frame in flight.
- `start`=1 in the `done` cycle is accepted, since `busy`=0 then. The next frame's first sync bit follows on the next cycle, so there is no idle bit between frames.
- `rst` asserted at any time, including mid-frame:
  - the frame is aborted immediately;
  - state -> IDLE;
  - all outputs take their reset values.
- Reset values: `ser_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `frame_cnt`=0, all internal counters 0.

## Timing
- All outputs are registered; none is combinational from `start` or `data_in`.
- `start` accepted at edge E0: after E0, `ser_out`=1 (first sync bit), `busy`=1, `bit_valid`=1.
- Each bit is held for exactly `CLKS_PER_BIT` cycles. `bit_valid` is high only in the first of those cycles.
- Frame bit count N = 13 + `PARITY_EN`; total busy period = (N + `GAP_BITS`) × `CLKS_PER_BIT` cycles.
- With the defaults, busy spans 16 cycles: `done`=1 and `busy`=0 after edge E16.
- Minimum frame-to-frame spacing = busy period + 1 cycle (the `done` cycle).

## Test plan
- **Reset values:** Assert `rst` for 3 cycles -> all outputs 0; drive `start` during reset -> no frame begins.
- **Basic frame (defaults):** `data_in`=0xA5 with `start` at E0 ->
  - `ser_out` after E0..E13 = 1,1,0,1,1, 1,0,1,0,0,1,0,1, 0 (parity);
  - after E14..E15 = 0,0;
  - after E16: `done`=1, `busy`=0, `frame_cnt`=1.
- **Parity and prescale:** `PARITY_EN`=1, `CLKS_PER_BIT`=3, `data_in`=0x01 ->
  - parity bit = 1;
  - each bit held 3 cycles;
  - `bit_valid` pulses 14 times, spaced 3 cycles apart;
  - `done` after 48 busy cycles.
- **Ignored and back-to-back starts:**
  - pulse `start` with 0xFF at E3 of a busy frame -> ignored, payload unchanged;
  - hold `start`=1 with 0x3C through the `done` cycle -> second frame starts on the next cycle, `frame_cnt`=2.
- **Mid-frame reset:** assert `rst` during the DATA state -> `ser_out`, `busy` and `frame_cnt` go to 0 immediately; a new `start` then produces a full frame from the first sync bit.
- **Counter wrap and no parity:** run 256 frames with `PARITY_EN`=0 -> `frame_cnt` wraps to 0; each frame has 13 `bit_valid` pulses followed by `GAP_BITS` zeros.
